// File: rtl/mmu_arb_pkg.sv
// mmu_arb_pkg: shared types and constants for the MMU port arbiter.
//   arb_state_e : arbiter FSM states
//   arb_owner_e : which requester owns the outstanding transaction
//   arb_req_t   : a candidate transaction as seen at grant time
package mmu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_BUSY = 2'd1,
    WR_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Fetch reads reuse the load path of the MMU: fixed tag, word access.
  localparam logic [4:0]  FETCH_TAG    = 5'd0;
  localparam logic [2:0]  FETCH_FUNC3  = 3'b010;
  // Data returned to the owner when the watchdog aborts a transaction.
  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

  typedef struct packed {
    logic        wr;
    arb_owner_e  own;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rtag;
    logic [2:0]  func3;
  } arb_req_t;

endpackage

// File: rtl/mmu_arbiter_if.sv
// mmu_arbiter_if: bundles the fetch port, the data (load/store) port, the
// MMU port and the arbiter status flags.
//   master : the arbiter (drives grants, completions, MMU requests, status)
//   slave  : the surroundings (requesters and the MMU)
interface mmu_arbiter_if;
  // fetch port
  logic        if_rd_req;
  logic [31:0] if_rd_addr;
  logic        if_gnt;
  logic        if_rd_valid;
  logic [31:0] if_rd_data;
  // data port
  logic        dm_rd_req;
  logic        dm_wr_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wr_data;
  logic [4:0]  dm_reg;
  logic [2:0]  dm_func3;
  logic        dm_gnt;
  logic        dm_rd_valid;
  logic [31:0] dm_rd_data;
  logic [4:0]  dm_rd_valid_reg;
  logic [2:0]  dm_rd_valid_func3;
  logic        dm_wr_done;
  logic [4:0]  dm_wr_done_reg;
  // MMU read channel
  logic        mmu_rd_req;
  logic [31:0] mmu_rd_addr;
  logic [4:0]  mmu_rd_req_reg;
  logic [2:0]  mmu_rd_req_func3;
  logic        mmu_rd_valid;
  logic [31:0] mmu_rd_data;
  logic [4:0]  mmu_rd_valid_reg;
  logic [2:0]  mmu_rd_valid_func3;
  // MMU write channel
  logic        mmu_wr_req;
  logic [31:0] mmu_wr_addr;
  logic [31:0] mmu_wr_data;
  logic [4:0]  mmu_wr_req_reg;
  logic        mmu_wr_done;
  logic [4:0]  mmu_wr_done_reg;
  // status
  logic        busy;
  logic        timeout_err;

  modport master (
    input  if_rd_req, if_rd_addr,
    output if_gnt, if_rd_valid, if_rd_data,
    input  dm_rd_req, dm_wr_req, dm_addr, dm_wr_data, dm_reg, dm_func3,
    output dm_gnt, dm_rd_valid, dm_rd_data, dm_rd_valid_reg, dm_rd_valid_func3,
    output dm_wr_done, dm_wr_done_reg,
    output mmu_rd_req, mmu_rd_addr, mmu_rd_req_reg, mmu_rd_req_func3,
    input  mmu_rd_valid, mmu_rd_data, mmu_rd_valid_reg, mmu_rd_valid_func3,
    output mmu_wr_req, mmu_wr_addr, mmu_wr_data, mmu_wr_req_reg,
    input  mmu_wr_done, mmu_wr_done_reg,
    output busy, timeout_err
  );

  modport slave (
    output if_rd_req, if_rd_addr,
    input  if_gnt, if_rd_valid, if_rd_data,
    output dm_rd_req, dm_wr_req, dm_addr, dm_wr_data, dm_reg, dm_func3,
    input  dm_gnt, dm_rd_valid, dm_rd_data, dm_rd_valid_reg, dm_rd_valid_func3,
    input  dm_wr_done, dm_wr_done_reg,
    input  mmu_rd_req, mmu_rd_addr, mmu_rd_req_reg, mmu_rd_req_func3,
    output mmu_rd_valid, mmu_rd_data, mmu_rd_valid_reg, mmu_rd_valid_func3,
    input  mmu_wr_req, mmu_wr_addr, mmu_wr_data, mmu_wr_req_reg,
    output mmu_wr_done, mmu_wr_done_reg,
    input  busy, timeout_err
  );
endinterface

// File: rtl/mmu_arb_wdog.sv
// mmu_arb_wdog: watchdog counter for the outstanding MMU transaction.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_clr         : restart the count (transaction granted)
//   i_en          : count this cycle (transaction outstanding)
//   o_expire      : count has reached TIMEOUT_CYCLES-1
module mmu_arb_wdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)    r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + CW'(1);
  end

  // Busy cycle k sees count k-1, so this fires on the last allowed cycle.
  assign o_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mmu_arbiter.sv
// mmu_arbiter: shares the single MMU read/write port between the fetch read
// port and the decode-stage load/store port. One transaction outstanding at
// a time; completions are routed by the recorded owner, never by tag; a
// watchdog aborts transactions that never complete.
//   i_clk, i_rstn : clock (cpu_clk_aon), asynchronous active-low reset
//   bus           : mmu_arbiter_if.master - fetch, data, MMU ports + status
// Parameter TIMEOUT_CYCLES (>=2): busy cycles before the watchdog aborts.
// Macro MMU_ARB_RR_EN: round-robin between the ports on conflict; when not
// defined, the data port always beats fetch.
module mmu_arbiter
  import mmu_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  mmu_arbiter_if.master bus
);

  arb_state_e r_state;
  arb_owner_e r_owner;
`ifdef MMU_ARB_RR_EN
  arb_owner_e r_last;
`endif

  logic        r_if_gnt, r_dm_gnt;
  logic        r_if_vld, r_dm_vld, r_wr_done, r_timeout;
  logic [31:0] r_if_data, r_dm_data;
  logic [4:0]  r_dm_vreg, r_wr_done_reg;
  logic [2:0]  r_dm_vf3;
  logic        r_mrd_req, r_mwr_req;
  logic [31:0] r_mrd_addr, r_mwr_addr, r_mwr_data;
  logic [4:0]  r_mrd_reg, r_mwr_reg;
  logic [2:0]  r_mrd_f3;

  logic     w_if_cand, w_dm_cand, w_pick_dm, w_grant, w_expire, w_busy;
  arb_req_t w_req;

  assign w_busy = (r_state != IDLE);

  // Candidates only exist in IDLE; a store beats a load on the data port.
  always_comb begin
    w_dm_cand = (r_state == IDLE) && (bus.dm_wr_req || bus.dm_rd_req);
    w_if_cand = (r_state == IDLE) && bus.if_rd_req;
`ifdef MMU_ARB_RR_EN
    w_pick_dm = w_dm_cand && (!w_if_cand || (r_last == OWN_IF));
`else
    w_pick_dm = w_dm_cand;
`endif
    w_grant   = w_dm_cand || w_if_cand;
    w_req     = '0;
    if (w_pick_dm) begin
      w_req.wr    = bus.dm_wr_req;
      w_req.own   = OWN_DM;
      w_req.addr  = bus.dm_addr;
      w_req.data  = bus.dm_wr_data;
      w_req.rtag  = bus.dm_reg;
      w_req.func3 = bus.dm_func3;
    end else begin
      w_req.wr    = 1'b0;
      w_req.own   = OWN_IF;
      w_req.addr  = bus.if_rd_addr;
      w_req.rtag  = FETCH_TAG;
      w_req.func3 = FETCH_FUNC3;
    end
  end

  mmu_arb_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clr    (w_grant),
    .i_en     (w_busy),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state       <= IDLE;
      r_owner       <= OWN_IF;
`ifdef MMU_ARB_RR_EN
      r_last        <= OWN_IF;
`endif
      r_if_gnt      <= 1'b0;
      r_dm_gnt      <= 1'b0;
      r_if_vld      <= 1'b0;
      r_dm_vld      <= 1'b0;
      r_wr_done     <= 1'b0;
      r_timeout     <= 1'b0;
      r_if_data     <= '0;
      r_dm_data     <= '0;
      r_dm_vreg     <= '0;
      r_dm_vf3      <= '0;
      r_wr_done_reg <= '0;
      r_mrd_req     <= 1'b0;
      r_mwr_req     <= 1'b0;
      r_mrd_addr    <= '0;
      r_mrd_reg     <= '0;
      r_mrd_f3      <= '0;
      r_mwr_addr    <= '0;
      r_mwr_data    <= '0;
      r_mwr_reg     <= '0;
    end else begin
      // every strobe is a single-cycle pulse
      r_if_gnt  <= 1'b0;
      r_dm_gnt  <= 1'b0;
      r_if_vld  <= 1'b0;
      r_dm_vld  <= 1'b0;
      r_wr_done <= 1'b0;
      r_mrd_req <= 1'b0;
      r_mwr_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_req.own;
`ifdef MMU_ARB_RR_EN
            r_last  <= w_req.own;
`endif
            if (w_req.own == OWN_DM) r_dm_gnt <= 1'b1;
            else                     r_if_gnt <= 1'b1;
            if (w_req.wr) begin
              r_mwr_req  <= 1'b1;
              r_mwr_addr <= w_req.addr;
              r_mwr_data <= w_req.data;
              r_mwr_reg  <= w_req.rtag;
              r_state    <= WR_BUSY;
            end else begin
              r_mrd_req  <= 1'b1;
              r_mrd_addr <= w_req.addr;
              r_mrd_reg  <= w_req.rtag;
              r_mrd_f3   <= w_req.func3;
              r_state    <= RD_BUSY;
            end
          end
        end
        RD_BUSY: begin
          // a real completion on the expiry cycle still counts as success
          if (bus.mmu_rd_valid) begin
            if (r_owner == OWN_IF) begin
              r_if_vld  <= 1'b1;
              r_if_data <= bus.mmu_rd_data;
            end else begin
              r_dm_vld  <= 1'b1;
              r_dm_data <= bus.mmu_rd_data;
              r_dm_vreg <= bus.mmu_rd_valid_reg;
              r_dm_vf3  <= bus.mmu_rd_valid_func3;
            end
            r_state <= IDLE;
          end else if (w_expire) begin
            if (r_owner == OWN_IF) begin
              r_if_vld  <= 1'b1;
              r_if_data <= TIMEOUT_DATA;
            end else begin
              r_dm_vld  <= 1'b1;
              r_dm_data <= TIMEOUT_DATA;
              r_dm_vreg <= r_mrd_reg;
              r_dm_vf3  <= r_mrd_f3;
            end
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end
        end
        WR_BUSY: begin
          if (bus.mmu_wr_done) begin
            r_wr_done     <= 1'b1;
            r_wr_done_reg <= bus.mmu_wr_done_reg;
            r_state       <= IDLE;
          end else if (w_expire) begin
            r_wr_done     <= 1'b1;
            r_wr_done_reg <= r_mwr_reg;
            r_timeout     <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt            = r_if_gnt;
  assign bus.if_rd_valid       = r_if_vld;
  assign bus.if_rd_data        = r_if_data;
  assign bus.dm_gnt            = r_dm_gnt;
  assign bus.dm_rd_valid       = r_dm_vld;
  assign bus.dm_rd_data        = r_dm_data;
  assign bus.dm_rd_valid_reg   = r_dm_vreg;
  assign bus.dm_rd_valid_func3 = r_dm_vf3;
  assign bus.dm_wr_done        = r_wr_done;
  assign bus.dm_wr_done_reg    = r_wr_done_reg;
  assign bus.mmu_rd_req        = r_mrd_req;
  assign bus.mmu_rd_addr       = r_mrd_addr;
  assign bus.mmu_rd_req_reg    = r_mrd_reg;
  assign bus.mmu_rd_req_func3  = r_mrd_f3;
  assign bus.mmu_wr_req        = r_mwr_req;
  assign bus.mmu_wr_addr       = r_mwr_addr;
  assign bus.mmu_wr_data       = r_mwr_data;
  assign bus.mmu_wr_req_reg    = r_mwr_reg;
  assign bus.busy              = w_busy;
  assign bus.timeout_err       = r_timeout;

endmodule

// File: tb/tb_mmu_arbiter.sv
// Bench for mmu_arbiter: directed scenarios with literal expectations, then
// randomized traffic. A transaction-level model tracks the one outstanding
// transaction and is compared with the DUT on every falling edge.
module tb_mmu_arbiter;
  localparam int TO = 16;
`ifdef MMU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  always #5 i_clk = ~i_clk;

  mmu_arbiter_if bus();
  mmu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.i_clk(i_clk), .i_rstn(i_rstn), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic        if_gnt, dm_gnt, rd_req, wr_req, if_v, dm_v, wd;
    logic [31:0] if_d, dm_d;
    logic [4:0]  dm_vreg, wd_reg;
    logic [2:0]  dm_vf3;
  } exp_t;

  exp_t        e;
  bit          m_busy, m_own_dm, m_wr, m_last_dm, m_terr;
  int          m_age;            // busy cycles elapsed, counting the current one
  logic [31:0] m_addr, m_wdata;
  logic [4:0]  m_reg;
  logic [2:0]  m_f3;

  task automatic model_reset();
    e = '0; m_busy = 0; m_own_dm = 0; m_wr = 0; m_last_dm = 0; m_terr = 0;
    m_age = 0; m_addr = 0; m_wdata = 0; m_reg = 0; m_f3 = 0;
  endtask

  task automatic model_step();
    logic dmc, ifc, to_dm, done;
    logic [31:0] d;
    e = '0;
    if (!m_busy) begin
      dmc = bus.dm_wr_req | bus.dm_rd_req;
      ifc = bus.if_rd_req;
      if (dmc || ifc) begin
        to_dm = dmc && (!ifc || !RR || !m_last_dm);
        m_busy = 1; m_age = 1; m_own_dm = to_dm; m_last_dm = to_dm;
        if (to_dm) begin
          m_wr = bus.dm_wr_req; m_addr = bus.dm_addr; m_wdata = bus.dm_wr_data;
          m_reg = bus.dm_reg; m_f3 = bus.dm_func3; e.dm_gnt = 1;
        end else begin
          m_wr = 0; m_addr = bus.if_rd_addr; m_reg = 5'd0; m_f3 = 3'b010; e.if_gnt = 1;
        end
        e.wr_req = m_wr; e.rd_req = !m_wr;
      end
    end else begin
      done = m_wr ? bus.mmu_wr_done : bus.mmu_rd_valid;
      if (done || m_age == TO) begin
        d = done ? bus.mmu_rd_data : 32'h0;
        if (m_wr) begin
          e.wd = 1; e.wd_reg = done ? bus.mmu_wr_done_reg : m_reg;
        end else if (m_own_dm) begin
          e.dm_v = 1; e.dm_d = d;
          e.dm_vreg = done ? bus.mmu_rd_valid_reg : m_reg;
          e.dm_vf3  = done ? bus.mmu_rd_valid_func3 : m_f3;
        end else begin
          e.if_v = 1; e.if_d = d;
        end
        if (!done) m_terr = 1;
        m_busy = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic compare();
    chk("busy", bus.busy, m_busy);
    chk("timeout_err", bus.timeout_err, m_terr);
    chk("if_gnt", bus.if_gnt, e.if_gnt);
    chk("dm_gnt", bus.dm_gnt, e.dm_gnt);
    chk("mmu_rd_req", bus.mmu_rd_req, e.rd_req);
    chk("mmu_wr_req", bus.mmu_wr_req, e.wr_req);
    chk("if_rd_valid", bus.if_rd_valid, e.if_v);
    chk("dm_rd_valid", bus.dm_rd_valid, e.dm_v);
    chk("dm_wr_done", bus.dm_wr_done, e.wd);
    if (e.if_v || !i_rstn) chk("if_rd_data", bus.if_rd_data, e.if_d);
    if (e.dm_v || !i_rstn) begin
      chk("dm_rd_data", bus.dm_rd_data, e.dm_d);
      chk("dm_rd_valid_reg", bus.dm_rd_valid_reg, e.dm_vreg);
      chk("dm_rd_valid_func3", bus.dm_rd_valid_func3, e.dm_vf3);
    end
    if (e.wd || !i_rstn) chk("dm_wr_done_reg", bus.dm_wr_done_reg, e.wd_reg);
    if ((m_busy && !m_wr) || !i_rstn) begin
      chk("mmu_rd_addr", bus.mmu_rd_addr, m_addr);
      chk("mmu_rd_req_reg", bus.mmu_rd_req_reg, m_reg);
      chk("mmu_rd_req_func3", bus.mmu_rd_req_func3, m_f3);
    end
    if ((m_busy && m_wr) || !i_rstn) begin
      chk("mmu_wr_addr", bus.mmu_wr_addr, m_addr);
      chk("mmu_wr_data", bus.mmu_wr_data, m_wdata);
      chk("mmu_wr_req_reg", bus.mmu_wr_req_reg, m_reg);
    end
  endtask

  always @(posedge i_clk) if (i_rstn) model_step();
  always @(negedge i_clk) begin
    if (!i_rstn) model_reset();
    compare();
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic idle_inputs();
    bus.if_rd_req = 0; bus.if_rd_addr = 0;
    bus.dm_rd_req = 0; bus.dm_wr_req = 0; bus.dm_addr = 0; bus.dm_wr_data = 0;
    bus.dm_reg = 0; bus.dm_func3 = 0;
    bus.mmu_rd_valid = 0; bus.mmu_rd_data = 0; bus.mmu_rd_valid_reg = 0;
    bus.mmu_rd_valid_func3 = 0; bus.mmu_wr_done = 0; bus.mmu_wr_done_reg = 0;
  endtask

  initial begin
    int ng;
    bit resp, pend, pwr, kind;
    int dly;
    logic [3:0] seq, exp_seq;
    idle_inputs();
    model_reset();

    // reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mmu_rd_req", bus.mmu_rd_req, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    @(posedge i_clk); #3 i_rstn = 1;
    tick();

    // fetch read 0x100, MMU answers 5 cycles after the request pulse
    bus.if_rd_req = 1; bus.if_rd_addr = 32'h100;
    tick();
    bus.if_rd_req = 0;
    @(negedge i_clk);
    chk("f_if_gnt", bus.if_gnt, 1);
    chk("f_mmu_rd_req", bus.mmu_rd_req, 1);
    chk("f_mmu_rd_addr", bus.mmu_rd_addr, 32'h100);
    chk("f_mmu_func3", bus.mmu_rd_req_func3, 3'b010);
    repeat (5) tick();
    bus.mmu_rd_valid = 1; bus.mmu_rd_data = 32'hCAFE_F00D; bus.mmu_rd_valid_reg = 5'd9;
    tick();
    bus.mmu_rd_valid = 0;
    @(negedge i_clk);
    chk("f_if_rd_valid", bus.if_rd_valid, 1);
    chk("f_if_rd_data", bus.if_rd_data, 32'hCAFE_F00D);
    chk("f_dm_rd_valid", bus.dm_rd_valid, 0);
    chk("f_busy_after", bus.busy, 0);

    // fetch and data read together: data first, fetch 2 cycles after completion
    bus.if_rd_req = 1; bus.if_rd_addr = 32'h200;
    bus.dm_rd_req = 1; bus.dm_addr = 32'h300; bus.dm_reg = 5'd3; bus.dm_func3 = 3'd4;
    tick();
    bus.dm_rd_req = 0;
    @(negedge i_clk);
    chk("c_dm_gnt", bus.dm_gnt, 1);
    chk("c_if_gnt", bus.if_gnt, 0);
    tick();
    bus.mmu_rd_valid = 1; bus.mmu_rd_data = 32'h1234_5678;
    bus.mmu_rd_valid_reg = 5'd3; bus.mmu_rd_valid_func3 = 3'd4;
    tick();
    bus.mmu_rd_valid = 0;
    @(negedge i_clk);
    chk("c_dm_rd_valid", bus.dm_rd_valid, 1);
    chk("c_dm_rd_data", bus.dm_rd_data, 32'h1234_5678);
    chk("c_dm_rd_reg", bus.dm_rd_valid_reg, 5'd3);
    chk("c_if_gnt_early", bus.if_gnt, 0);
    tick();
    bus.if_rd_req = 0;
    @(negedge i_clk);
    chk("c_if_gnt_late", bus.if_gnt, 1);
    tick();
    bus.mmu_rd_valid = 1; bus.mmu_rd_data = 32'hAAAA_0001;
    tick();
    bus.mmu_rd_valid = 0;

    // store and load together: store first, load granted next
    tick();
    bus.dm_wr_req = 1; bus.dm_rd_req = 1; bus.dm_addr = 32'h40;
    bus.dm_wr_data = 32'hDEAD_BEEF; bus.dm_reg = 5'd7; bus.dm_func3 = 3'd0;
    tick();
    bus.dm_wr_req = 0;
    @(negedge i_clk);
    chk("w_mmu_wr_req", bus.mmu_wr_req, 1);
    chk("w_mmu_rd_req", bus.mmu_rd_req, 0);
    chk("w_mmu_wr_addr", bus.mmu_wr_addr, 32'h40);
    chk("w_mmu_wr_reg", bus.mmu_wr_req_reg, 5'd7);
    tick();
    bus.mmu_wr_done = 1; bus.mmu_wr_done_reg = 5'd7;
    tick();
    bus.mmu_wr_done = 0;
    @(negedge i_clk);
    chk("w_dm_wr_done", bus.dm_wr_done, 1);
    chk("w_dm_wr_done_reg", bus.dm_wr_done_reg, 5'd7);
    tick();
    bus.dm_rd_req = 0;
    @(negedge i_clk);
    chk("w_then_rd_req", bus.mmu_rd_req, 1);
    tick();
    bus.mmu_rd_valid = 1; bus.mmu_rd_valid_reg = 5'd7;
    tick();
    bus.mmu_rd_valid = 0;

    // watchdog: load never answered
    tick();
    bus.dm_rd_req = 1; bus.dm_addr = 32'h500; bus.dm_reg = 5'd12; bus.dm_func3 = 3'd5;
    tick();
    bus.dm_rd_req = 0;
    repeat (14) tick();
    @(negedge i_clk);
    chk("t_busy_c15", bus.busy, 1);
    chk("t_terr_c15", bus.timeout_err, 0);
    tick();
    @(negedge i_clk);
    chk("t_busy_c16", bus.busy, 1);
    tick();
    @(negedge i_clk);
    chk("t_dm_rd_valid", bus.dm_rd_valid, 1);
    chk("t_dm_rd_data", bus.dm_rd_data, 32'h0);
    chk("t_dm_rd_reg", bus.dm_rd_valid_reg, 5'd12);
    chk("t_dm_rd_func3", bus.dm_rd_valid_func3, 3'd5);
    chk("t_timeout_err", bus.timeout_err, 1);
    chk("t_busy_after", bus.busy, 0);
    tick();
    bus.mmu_rd_valid = 1; bus.mmu_rd_data = 32'hBAD; bus.mmu_rd_valid_reg = 5'd1;
    tick();
    bus.mmu_rd_valid = 0;
    @(negedge i_clk);
    chk("t_late_dropped", bus.dm_rd_valid, 0);
    chk("t_terr_sticky", bus.timeout_err, 1);

    // reset in the middle of a read; a late MMU answer is dropped
    tick();
    bus.if_rd_req = 1; bus.if_rd_addr = 32'h600;
    tick();
    bus.if_rd_req = 0;
    tick();
    #2 i_rstn = 0;
    @(negedge i_clk);
    chk("r_busy", bus.busy, 0);
    chk("r_timeout_err", bus.timeout_err, 0);
    chk("r_mmu_rd_addr", bus.mmu_rd_addr, 0);
    @(posedge i_clk); #3 i_rstn = 1;
    tick();
    bus.mmu_rd_valid = 1; bus.mmu_rd_data = 32'h7777;
    tick();
    bus.mmu_rd_valid = 0;
    @(negedge i_clk);
    chk("r_late_if_valid", bus.if_rd_valid, 0);
    chk("r_late_busy", bus.busy, 0);

    // both ports held for four transactions
    tick();
    bus.if_rd_req = 1; bus.dm_rd_req = 1; bus.dm_reg = 5'd2;
    ng = 0; resp = 0; seq = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      tick();
      bus.mmu_rd_valid = resp; resp = 0;
      if (bus.dm_gnt) begin seq[ng] = 1; ng++; resp = 1; end
      else if (bus.if_gnt) begin seq[ng] = 0; ng++; resp = 1; end
    end
    chk("h_grant_count", ng, 4);
    exp_seq = RR ? 4'b0101 : 4'b1111;
    for (int i = 0; i < 4; i++) chk("h_grant_owner", seq[i], exp_seq[i]);
    bus.if_rd_req = 0; bus.dm_rd_req = 0;
    tick();
    bus.mmu_rd_valid = 1;
    tick();
    bus.mmu_rd_valid = 0;

    // random traffic
    pend = 0; pwr = 0; dly = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.mmu_rd_valid = 0; bus.mmu_wr_done = 0;
      bus.mmu_rd_data = $urandom; bus.mmu_rd_valid_reg = 5'($urandom);
      bus.mmu_rd_valid_func3 = 3'($urandom); bus.mmu_wr_done_reg = 5'($urandom);
      if (bus.mmu_rd_req || bus.mmu_wr_req) begin
        pend = 1; pwr = bus.mmu_wr_req;
        dly = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4);
      end
      if (pend) begin
        if (dly == 0) begin
          kind = ($urandom_range(0, 7) == 0) ? !pwr : pwr;
          if (kind) bus.mmu_wr_done = 1; else bus.mmu_rd_valid = 1;
          pend = 0;
        end else dly--;
      end else if ($urandom_range(0, 30) == 0) begin
        if ($urandom_range(0, 1) == 0) bus.mmu_wr_done = 1; else bus.mmu_rd_valid = 1;
      end
      if ($urandom_range(0, 3) == 0) bus.if_rd_req = ~bus.if_rd_req;
      if ($urandom_range(0, 3) == 0) bus.dm_rd_req = ~bus.dm_rd_req;
      if ($urandom_range(0, 5) == 0) bus.dm_wr_req = ~bus.dm_wr_req;
      bus.if_rd_addr = $urandom; bus.dm_addr = $urandom; bus.dm_wr_data = $urandom;
      bus.dm_reg = 5'($urandom); bus.dm_func3 = 3'($urandom);
    end
    idle_inputs();
    repeat (TO + 4) tick();
    @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
